// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus slave port among NUM_INPUTS masters.
// Grant is registered, locked for the whole burst, and rotates past the last winner.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_lane
  import cbus_pkg::*;
(
  input  logic       i_sel,
  input  cbus_resp_t i_resp,
  output cbus_resp_t o_resp
);
  // Non-owners see an all-zero response, so their ready stays low and they hold.
  assign o_resp = i_sel ? i_resp : '0;
endmodule

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic [IDX_WIDTH-1:0]         grant_idx,
  output logic                         busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_sel, r_ptr;
  logic [IDX_WIDTH-1:0] w_winner;
  logic                 w_found;
  logic                 w_busy;

  // Lowest valid index above r_ptr wins; otherwise lowest valid at or below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NUM_INPUTS-1; i >= 0; i--) begin
      if (ireqs[i].valid && (IDX_WIDTH'(i) <= r_ptr)) begin
        w_found  = 1'b1;
        w_winner = IDX_WIDTH'(i);
      end
    end
    for (int i = NUM_INPUTS-1; i >= 0; i--) begin
      if (ireqs[i].valid && (IDX_WIDTH'(i) > r_ptr)) begin
        w_found  = 1'b1;
        w_winner = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_found) w_state_nxt = BUSY;
      BUSY: if (!ireqs[r_sel].valid || (oresp.ready && oresp.last)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= IDX_WIDTH'(NUM_INPUTS-1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_sel <= w_winner;
        r_ptr <= w_winner;
      end
    end
  end

  assign w_busy    = (r_state == BUSY);
  assign busy      = w_busy;
  assign grant_idx = r_sel;
  assign oreq      = w_busy ? ireqs[r_sel] : '0;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    cbus_rr_lane u_lane (
      .i_sel  (w_busy && (r_sel == IDX_WIDTH'(g))),
      .i_resp (oresp),
      .o_resp (iresps[g])
    );
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboarded bench for cbus_rr_arbiter with four masters and a one-wait-state slave.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  cbus_req_t  [N-1:0]    ireqs;
  cbus_resp_t [N-1:0]    iresps;
  cbus_req_t             oreq;
  cbus_resp_t            oresp;
  logic [IW-1:0]         grant_idx;
  logic                  busy;

  always #5 clk = ~clk;

  cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
  } exp_t;

  exp_t      sbq[$];
  cbus_req_t mq[N][$];
  int        checks = 0;
  int        failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cbus_req_t mk(input logic [31:0] a, input logic [3:0] len);
    cbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.addr   = a;
    r.len    = len;
    r.size   = 3'd2;
    r.strobe = 4'hf;
    r.burst  = (len != 0) ? 2'b01 : 2'b00;
    return r;
  endfunction

  task automatic push_exp(input int idx, input logic [31:0] a, input int beats);
    exp_t e;
    e.idx  = idx;
    e.addr = a;
    for (int k = 0; k < beats; k++) sbq.push_back(e);
  endtask

  function automatic bit mq_pending();
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((busy || sbq.size() != 0 || mq_pending()) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, sbq.size());
      sbq.delete();
      for (int i = 0; i < N; i++) mq[i].delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Slave: one wait cycle after oreq first goes valid, then one beat per cycle.
  initial begin
    int wcnt;
    int beat;
    wcnt  = 0;
    beat  = 0;
    oresp = '0;
    forever begin
      @(negedge clk);
      oresp = '0;
      if (!resetn) begin
        wcnt = 0;
        beat = 0;
      end else if (oreq.valid && wcnt >= 1) begin
        oresp.ready = 1'b1;
        oresp.last  = (beat == int'(oreq.len));
        oresp.data  = oreq.addr + 32'(beat);
        if (oresp.last) begin
          beat = 0;
          wcnt = 0;
        end else beat++;
      end else if (oreq.valid) wcnt++;
      else begin
        wcnt = 0;
        beat = 0;
      end
    end
  end

  // Masters: present the head of their queue, retire it on ready+last.
  initial begin
    ireqs = '0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (ireqs[i].valid && iresps[i].ready && iresps[i].last && mq[i].size() != 0)
          void'(mq[i].pop_front());
        ireqs[i] = (mq[i].size() != 0) ? mq[i][0] : '0;
      end
    end
  end

  // Monitor: every accepted beat must match the scoreboard head.
  initial begin
    exp_t e;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (resetn) begin
        if (prev_done) chk("bubble_after_last", 32'(busy), 32'd0);
        if (!busy) chk("idle_oreq_valid", 32'(oreq.valid), 32'd0);
        prev_done = 1'b0;
        if (busy && oreq.valid && oresp.ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: idx %0d addr %0h, expected no beat", grant_idx, oreq.addr);
          end else begin
            e = sbq.pop_front();
            chk("beat_grant_idx", 32'(grant_idx), 32'(e.idx));
            chk("beat_addr", oreq.addr, e.addr);
            for (int i = 0; i < N; i++)
              chk("beat_iresp_ready", 32'(iresps[i].ready), 32'(i == e.idx));
          end
          prev_done = oresp.last;
        end
      end else prev_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held low for three cycles with no requests.
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_oreq_valid", 32'(oreq.valid), 32'd0);
      chk("rst_iresps_zero", 32'(iresps == '0), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_iresps_zero", 32'(iresps == '0), 32'd1);
    end

    // Single master, single beat: one arbitration cycle, one wait cycle.
    @(posedge clk); #1;
    mq[1].push_back(mk(32'h8000_0000, 4'd0));
    push_exp(1, 32'h8000_0000, 1);
    @(posedge clk);
    @(negedge clk); #1;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant_idx", 32'(grant_idx), 32'd1);
    chk("t1_oreq_valid", 32'(oreq.valid), 32'd1);
    chk("t1_oreq_addr", oreq.addr, 32'h8000_0000);
    chk("t1_wait_ready", 32'(iresps[1].ready), 32'd0);
    @(negedge clk); #1;
    chk("t1_ready", 32'(iresps[1].ready), 32'd1);
    chk("t1_last", 32'(iresps[1].last), 32'd1);
    @(negedge clk); #1;
    chk("t1_busy_after", 32'(busy), 32'd0);
    wait_quiet("t1");

    // Contention: ptr=1, so master 0 first, then alternate.
    @(posedge clk); #1;
    mq[0].push_back(mk(32'h0000_0100, 4'd0));
    mq[0].push_back(mk(32'h0000_0104, 4'd0));
    mq[1].push_back(mk(32'h0000_0200, 4'd0));
    mq[1].push_back(mk(32'h0000_0204, 4'd0));
    push_exp(0, 32'h0000_0100, 1);
    push_exp(1, 32'h0000_0200, 1);
    push_exp(0, 32'h0000_0104, 1);
    push_exp(1, 32'h0000_0204, 1);
    wait_quiet("t2");

    // Burst lock: four beats of master 0 before master 1 gets in.
    @(posedge clk); #1;
    mq[0].push_back(mk(32'h0000_C000, 4'd3));
    mq[1].push_back(mk(32'h0000_D000, 4'd0));
    push_exp(0, 32'h0000_C000, 4);
    push_exp(1, 32'h0000_D000, 1);
    wait_quiet("t3");

    // Wrap-around: park ptr at 3, then masters 0 and 2 compete.
    @(posedge clk); #1;
    mq[3].push_back(mk(32'h0000_E000, 4'd0));
    push_exp(3, 32'h0000_E000, 1);
    wait_quiet("t4a");
    @(posedge clk); #1;
    mq[2].push_back(mk(32'h0000_0020, 4'd0));
    mq[0].push_back(mk(32'h0000_0010, 4'd0));
    push_exp(0, 32'h0000_0010, 1);
    push_exp(2, 32'h0000_0020, 1);
    wait_quiet("t4b");

    // Abort: master 2 drops valid after its second beat.
    @(posedge clk); #1;
    mq[2].push_back(mk(32'h0000_F000, 4'd3));
    push_exp(2, 32'h0000_F000, 2);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); #3;
    mq[2].delete();
    @(negedge clk); #3;
    chk("ab_oreq_valid", 32'(oreq.valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd1);
    chk("ab_grant_idx", 32'(grant_idx), 32'd2);
    @(negedge clk); #1;
    chk("ab_idle", 32'(busy), 32'd0);
    wait_quiet("t5");

    // Async reset mid-burst: outputs clear at once, master 0 wins afterwards.
    @(posedge clk); #1;
    mq[1].push_back(mk(32'h0000_1000, 4'd3));
    push_exp(1, 32'h0000_1000, 1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); #3;
    resetn = 1'b0;
    mq[1].delete();
    mq[2].push_back(mk(32'h0000_0040, 4'd0));
    mq[0].push_back(mk(32'h0000_0030, 4'd0));
    push_exp(0, 32'h0000_0030, 1);
    push_exp(2, 32'h0000_0040, 1);
    #1;
    chk("rs_oreq_valid", 32'(oreq.valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_grant_idx", 32'(grant_idx), 32'd0);
    chk("rs_iresps_zero", 32'(iresps == '0), 32'd1);
    @(negedge clk); #4;
    resetn = 1'b1;
    wait_quiet("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Registered round-robin arbiter that shares one CBus slave port among NUM_INPUTS masters, e.g. the I-cache and D-cache sharing the memory bus.
- It replaces fixed-priority combinational multiplexing. It locks the grant for a whole burst transaction and rotates priority so no master starves.
- Sits between the cache/uncached request paths and the single outgoing cbus_req_t/cbus_resp_t link.

Parameters:
- NUM_INPUTS, 2, number of requesting masters (>= 1).
- IDX_WIDTH, (NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1), width of grant index (localparam).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- ireqs  input  cbus_req_t x NUM_INPUTS  per-master requests.
- iresps  output  cbus_resp_t x NUM_INPUTS  per-master responses.
- oreq  output  cbus_req_t  request to the shared slave.
- oresp  input  cbus_resp_t  response from the shared slave.
- grant_idx  output  IDX_WIDTH  index of the current/last granted master.
- busy  output  1  high while a transaction is owned (state BUSY).

Behaviour:
- State machine: IDLE, BUSY. Registers: state, sel (IDX_WIDTH), ptr (IDX_WIDTH, last granted index).
- Reset (async, resetn=0):
  - state=IDLE, sel=0, ptr=NUM_INPUTS-1, so master 0 has first priority.
  - Outputs during reset: oreq='0, iresps='0, busy=0, grant_idx=0.
  - Reset asserted mid-transaction abandons the transaction immediately. Outputs go to '0 in the same cycle (async).
- IDLE:
  - Outputs: oreq='0, all iresps='0.
  - Winner = first i with ireqs[i].valid, searching ptr+1, ptr+2, ... with wrap modulo NUM_INPUTS.
  - If a winner exists: sel<=winner, ptr<=winner, state<=BUSY at the next edge.
  - If no master is valid: stay IDLE and leave ptr unchanged.
  - Arbitration costs exactly one cycle: a request first seen valid at edge N appears on oreq in cycle N+1.
- BUSY:
  - oreq = ireqs[sel]. iresps[sel] = oresp. All other iresps='0, so their ready stays 0 and they hold their requests.
  - Transaction completes on a cycle with oresp.ready && oresp.last: state<=IDLE.
  - After completion at least one IDLE cycle follows before the next grant. oreq.valid is 0 during that cycle.
  - Abort: if ireqs[sel].valid==0 in BUSY (protocol violation or flush), state<=IDLE next edge. oreq mirrors ireqs[sel] that cycle (valid=0).
  - Requests from other masters during BUSY are ignored until IDLE. No preemption.
- Fairness: with all masters continuously requesting, grants cycle 0,1,...,N-1,0. Each master waits at most N-1 transactions.
- NUM_INPUTS==1: degenerates to a registered pass-through with a 1-cycle bubble per transaction. The winner is always 0.
- grant_idx = sel. It is valid when busy=1 and holds its last value in IDLE.
- busy = (state==BUSY).
- Single-beat transactions (len=0) complete on the first ready beat with last=1. Multi-beat bursts stay locked across all beats. Intermediate ready beats with last=0 keep BUSY.
- Request payload fields (addr, size, strobe, data, len, burst, is_write) are forwarded combinationally from ireqs[sel] in BUSY. The arbiter does not register them.

Test Plan:
- Reset, then idle: resetn low 3 cycles, no requests -> oreq.valid=0, iresps all '0, busy=0, grant_idx=0 throughout.
- Single master: ireqs[1] valid read addr=0x8000_0000 len=0 at edge 5 -> oreq carries it from cycle 6. Slave ready+last in cycle 7 -> iresps[1].ready=1 in cycle 7, busy=0 from cycle 8.
- Contention/fairness: masters 0 and 1 both valid continuously, slave replies ready+last one cycle after each grant, NUM_INPUTS=2 -> grant order 0,1,0,1. Non-granted iresps.ready is always 0.
- Burst lock: master 0 len=3 (4 beats), master 1 valid throughout -> oreq stays master 0 for all 4 beats (last only on beat 4). Master 1 is granted only after the following IDLE cycle.
- Wrap-around with NUM_INPUTS=4: ptr=3, masters 0 and 2 valid -> master 0 granted. After completion -> master 2 granted.
- Abort and async reset: master 2 granted, ireqs[2].valid drops mid-burst -> IDLE next edge. Separately, resetn pulsed low mid-burst -> oreq.valid=0 immediately, ptr=NUM_INPUTS-1, and master 0 wins the next arbitration.
